sram_bank_ctrl: RTL

SRAM_BANK_CTRL -- requirements
Module: sram_bank_ctrl

---
 rtl/sram_bank_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/sram_bank_ctrl.sv
// Banked SRAM front end: decodes requests onto shared bank buses and returns
// read data in order through a 3-entry response FIFO with credit-style flow control.
module sram_bank_ctrl #(
  parameter  int DW      = 20,
  parameter  int BANK_AW = 9,
  parameter  int NBANK   = 4,
  localparam int BSEL_W  = $clog2(NBANK),
  localparam int AW      = BANK_AW + BSEL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [AW-1:0]       req_addr,
  input  logic [DW-1:0]       req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DW-1:0]       rsp_data,
  output logic [BANK_AW-1:0]  ADDRESS,
  output logic [DW-1:0]       wd,
  output logic [NBANK-1:0]    banksel,
  output logic                read,
  output logic                write,
  input  logic [NBANK*DW-1:0] bank_dout
);

  logic [1:0]             count_q, count_d;
  logic [1:0]             wptr_q, wptr_d;
  logic [1:0]             rptr_q, rptr_d;
  logic                   pend_q, pend_d;
  logic [BSEL_W-1:0]      rd_bank_q, rd_bank_d;
  logic [DW-1:0]          mem_q [3];

  logic                   acc, push, pop;
  logic [2:0]             occ;
  logic [BSEL_W-1:0]      req_bank;
  logic [NBANK-1:0][DW-1:0] bank_words;
  logic [DW-1:0]          rd_word;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign occ       = {1'b0, count_q} + {2'b0, pend_q};
  assign req_ready = rst_n & (occ < 3'd3);
  assign acc       = req_valid & req_ready;
  assign req_bank  = req_addr[AW-1 -: BSEL_W];

  assign ADDRESS = req_addr[BANK_AW-1:0];
  assign wd      = req_wdata;
  assign read    = acc & ~req_write;
  assign write   = acc & req_write;

  always_comb begin
    banksel = '0;
    if (acc) banksel[req_bank] = 1'b1;
  end

  assign bank_words = bank_dout;
  assign rd_word    = bank_words[rd_bank_q];

  assign push      = pend_q;
  assign rsp_valid = rst_n & (count_q != 2'd0);
  assign rsp_data  = mem_q[rptr_q];
  assign pop       = rsp_valid & rsp_ready;

  always_comb begin
    count_d   = count_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    pend_d    = read;
    rd_bank_d = rd_bank_q;
    if (read) rd_bank_d = req_bank;
    if (push) wptr_d = inc3(wptr_q);
    if (pop)  rptr_d = inc3(rptr_q);
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      pend_q    <= 1'b0;
      rd_bank_q <= '0;
    end else begin
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      pend_q    <= pend_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Storage is qualified by the pointers, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= rd_word;
  end

endmodule
